// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode/write-back stage with register file, forwarding and E pipeline register
module decode_stage #(
  parameter logic [63:0] STACK_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  D_stat,
  input  logic        E_bubble,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] M_valE,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_stat,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);
  logic [63:0] rf_q [15];
  logic [3:0]  d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB, rd_a, rd_b;
  function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rf);
    return src == 4'hF ? 64'd0 :
           src == e_dstE ? e_valE :
           src == M_dstM ? m_valM :
           src == M_dstE ? M_valE :
           src == W_dstM ? W_valM :
           src == W_dstE ? W_valE : rf;
  endfunction
  always_comb begin
    d_srcA = (D_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? D_rA :
             (D_icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    d_srcB = (D_icode inside {4'h4, 4'h5, 4'h6}) ? D_rB :
             (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    d_dstE = (D_icode inside {4'h2, 4'h3, 4'h6}) ? D_rB :
             (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    d_dstM = (D_icode inside {4'h5, 4'hB}) ? D_rA : 4'hF;
    rd_a   = d_srcA == 4'hF ? 64'd0 : rf_q[d_srcA];
    rd_b   = d_srcB == 4'hF ? 64'd0 : rf_q[d_srcB];
    d_valA = (D_icode inside {4'h7, 4'h8}) ? D_valP : fwd(d_srcA, rd_a);
    d_valB = fwd(d_srcB, rd_b);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf_q[i] <= (i == 4) ? STACK_INIT : 64'd0;
    end else begin
      if (W_dstE != 4'hF) rf_q[W_dstE] <= W_valE;
      if (W_dstM != 4'hF) rf_q[W_dstM] <= W_valM;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || E_bubble) begin
      E_icode <= 4'h1;
      E_ifun  <= 4'h0;
      E_stat  <= 4'h8;
      E_valC  <= 64'd0;
      E_valA  <= 64'd0;
      E_valB  <= 64'd0;
      E_dstE  <= 4'hF;
      E_dstM  <= 4'hF;
      E_srcA  <= 4'hF;
      E_srcB  <= 4'hF;
    end else begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_stat  <= D_stat;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random and directed self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;
  localparam logic [63:0] SP0 = 64'h200;
  logic clk, reset, E_bubble;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [63:0] D_valC, D_valP;
  logic [3:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0] d_srcA, d_srcB, E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [63:0] regs [15];
  logic [3:0] x_icode, x_ifun, x_stat, x_dstE, x_dstM, x_srcA, x_srcB;
  logic [63:0] x_valC, x_valA, x_valB;
  int total = 0, fails = 0;

  decode_stage #(.STACK_INIT(SP0)) dut (
    .clk(clk), .reset(reset), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE),
    .m_valM(m_valM), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sel(input logic [3:0] ic, input logic [15:0] m_reg, input logic [15:0] m_sp, input logic [3:0] r);
    return m_reg[ic] ? r : m_sp[ic] ? 4'h4 : 4'hF;
  endfunction

  function automatic logic [63:0] fv(input logic [3:0] src);
    logic [3:0] pd [5];
    logic [63:0] pv [5];
    pd = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    pv = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (src == 4'hF) return 64'd0;
    for (int i = 0; i < 5; i++) if (pd[i] == src) return pv[i];
    return regs[src];
  endfunction

  task automatic cyc();
    #1;
    x_srcA = sel(D_icode, 16'h0454, 16'h0A00, D_rA);
    x_srcB = sel(D_icode, 16'h0070, 16'h0F00, D_rB);
    x_dstE = sel(D_icode, 16'h004C, 16'h0F00, D_rB);
    x_dstM = sel(D_icode, 16'h0820, 16'h0000, D_rA);
    chk("d_srcA", d_srcA, x_srcA);
    chk("d_srcB", d_srcB, x_srcB);
    x_valA = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : fv(x_srcA);
    x_valB = fv(x_srcB);
    {x_icode, x_ifun, x_stat, x_valC} = {D_icode, D_ifun, D_stat, D_valC};
    if (reset || E_bubble) begin
      {x_icode, x_ifun, x_stat, x_valC, x_valA, x_valB} = {4'h1, 4'h0, 4'h8, 192'd0};
      {x_dstE, x_dstM, x_srcA, x_srcB} = 16'hFFFF;
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 15; i++) regs[i] = 64'd0;
      regs[4] = SP0;
    end else begin
      if (W_dstE != 4'hF) regs[W_dstE] = W_valE;
      if (W_dstM != 4'hF) regs[W_dstM] = W_valM;
    end
    #1;
    chk("E_icode", E_icode, x_icode);
    chk("E_ifun", E_ifun, x_ifun);
    chk("E_stat", E_stat, x_stat);
    chk("E_valC", E_valC, x_valC);
    chk("E_valA", E_valA, x_valA);
    chk("E_valB", E_valB, x_valB);
    chk("E_dstE", E_dstE, x_dstE);
    chk("E_dstM", E_dstM, x_dstM);
    chk("E_srcA", E_srcA, x_srcA);
    chk("E_srcB", E_srcB, x_srcB);
  endtask

  task automatic idle_fwd();
    {e_dstE, M_dstE, M_dstM, W_dstE, W_dstM} = 20'hFFFFF;
  endtask

  task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    {D_icode, D_ifun, D_rA, D_rB, D_stat} = {ic, 4'h0, ra, rb, 4'h8};
  endtask

  function automatic logic [3:0] rid();
    int k;
    k = $urandom_range(0, 9);
    return k < 6 ? 4'(k) : k < 8 ? 4'hF : 4'($urandom_range(0, 14));
  endfunction

  initial begin
    for (int i = 0; i < 15; i++) regs[i] = 64'd0;
    reset = 1; E_bubble = 0;
    set_d(4'h1, 4'hF, 4'hF);
    D_valC = 0; D_valP = 0;
    idle_fwd();
    {e_valE, M_valE, m_valM, W_valE, W_valM} = '0;
    cyc();
    chk("reset_icode", E_icode, 4'h1);
    chk("reset_stat", E_stat, 4'h8);
    chk("reset_dstE", E_dstE, 4'hF);
    reset = 0;
    set_d(4'h2, 4'h4, 4'h0);
    cyc();
    chk("rsp_init", E_valA, 64'h200);
    set_d(4'h6, 4'h0, 4'h3);
    W_dstE = 4'h0; W_valE = 64'd5;
    cyc();
    chk("w_fwd", E_valA, 64'd5);
    idle_fwd();
    set_d(4'h2, 4'h0, 4'h1);
    cyc();
    chk("rf_read", E_valA, 64'd5);
    set_d(4'h2, 4'h2, 4'h1);
    e_dstE = 4'h2; e_valE = 64'h11;
    M_dstM = 4'h2; m_valM = 64'h22;
    W_dstE = 4'h2; W_valE = 64'h33;
    cyc();
    chk("prio_e", E_valA, 64'h11);
    e_dstE = 4'hF;
    cyc();
    chk("prio_m", E_valA, 64'h22);
    idle_fwd();
    set_d(4'h8, 4'hF, 4'hF);
    D_valP = 64'h40;
    cyc();
    chk("call_valA", E_valA, 64'h40);
    chk("call_valB", E_valB, 64'h200);
    chk("call_dstE", E_dstE, 4'h4);
    chk("call_dstM", E_dstM, 4'hF);
    set_d(4'h1, 4'hF, 4'hF);
    W_dstE = 4'h4; W_valE = 64'h208;
    W_dstM = 4'h4; W_valM = 64'h77;
    cyc();
    idle_fwd();
    set_d(4'h2, 4'h4, 4'h0);
    cyc();
    chk("pop_rsp", E_valA, 64'h77);
    set_d(4'h5, 4'h1, 4'h2);
    E_bubble = 1;
    cyc();
    chk("bubble_icode", E_icode, 4'h1);
    chk("bubble_dstM", E_dstM, 4'hF);
    E_bubble = 0;
    cyc();
    chk("redecode_icode", E_icode, 4'h5);
    chk("redecode_dstM", E_dstM, 4'h1);
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 59) == 0;
      E_bubble = $urandom_range(0, 9) == 0;
      D_icode = 4'($urandom); D_ifun = 4'($urandom);
      D_rA = rid(); D_rB = rid(); D_stat = 4'($urandom);
      D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
      e_dstE = rid(); M_dstE = rid(); M_dstM = rid(); W_dstE = rid(); W_dstM = rid();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
      W_valM = {$urandom, $urandom};
      cyc();
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Decode/write-back stage of the five-stage Y86-64 pipeline, directly downstream of the fetch stage. It consumes the D pipeline register (`D_icode`, `D_ifun`, `D_rA`, `D_rB`, `D_valC`, `D_valP`, `D_stat`) and owns the 15-entry register file. It resolves source operands through a fixed-priority forwarding network and loads the E pipeline register. It also accepts the W-stage write-back and exposes `d_srcA`/`d_srcB` to the hazard-control unit.

## Interface
Parameters:
- `STACK_INIT`, default 64'd0: reset value of register 4 (%rsp).

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `D_icode`, `D_ifun`, `D_rA`, `D_rB`  in  4 each  decode register fields
- `D_valC`, `D_valP`  in  64 each  constant and next PC
- `D_stat`  in  4  status: 1000 AOK, 0100 HLT, 0010 ADR, 0001 INS
- `E_bubble`  in  1  load nop into E
- `e_dstE`  in  4, `e_valE`  in  64  execute-stage result (`e_dstE` already forced to 4'hF on a failed cmov)
- `M_dstE`, `M_dstM`  in  4 each; `M_valE`, `m_valM`  in  64 each  memory-stage results
- `W_dstE`, `W_dstM`  in  4 each; `W_valE`, `W_valM`  in  64 each  write-back results
- `d_srcA`, `d_srcB`  out  4 each  combinational source IDs for hazard control
- `E_icode`, `E_ifun`, `E_stat`  out  4 each  E register
- `E_valC`, `E_valA`, `E_valB`  out  64 each  E register
- `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB`  out  4 each  E register

## Operation
- Register ID 4'hF means "none". It is never read from the array (reads yield 0) and never written.
- `d_srcA` is `D_rA` for icode 2, 4, 6, A. It is 4 for icode 9, B. Otherwise F.
- `d_srcB` is `D_rB` for icode 4, 5, 6. It is 4 for icode 8, 9, A, B. Otherwise F.
- `d_dstE` is `D_rB` for icode 2, 3, 6. It is 4 for icode 8, 9, A, B. Otherwise F.
- `d_dstM` is `D_rA` for icode 5, B. Otherwise F.
- Forwarding priority for `d_valA`, first match wins:
  - `D_valP` if icode is 7 or 8.
  - `e_valE` if src==`e_dstE`.
  - `m_valM` if src==`M_dstM`.
  - `M_valE` if src==`M_dstE`.
  - `W_valM` if src==`W_dstM`.
  - `W_valE` if src==`W_dstE`.
  - Register file.
- `d_valB` uses the same priority without the `D_valP` term.
- A src of F never matches a dst of F. The result is 0.
- Register file: 15×64.
  - Two combinational read ports.
  - Two write ports on `posedge clk`: `W_dstE`←`W_valE` and `W_dstM`←`W_valM`.
  - If both write ports target the same register, the M port wins.
- E register load precedence on `posedge clk`:
  - `reset`: E set to nop (icode 1, ifun 0, stat 1000, all dst/src F, all values 0). Registers 0–14 cleared, then register 4 = `STACK_INIT`.
  - `E_bubble`: same nop contents as reset. The register file is still written from W.
  - Otherwise: E_icode/ifun/stat/valC come from D. E_valA/valB come from `d_valA`/`d_valB`. E_dstE/dstM/srcA/srcB come from the computed IDs.
- Unknown icode (C–F): all IDs F. Fields pass through with `D_stat` unchanged. Status is not re-encoded here.
- There is no stall input. E holding is never required in this pipeline.

## Timing
- Decode is combinational from D; E updates one cycle after D presents.
- A write-back value is visible in the array on the cycle after W. Same-cycle consumers get it through W forwarding, so there is no lost cycle.
- Reset asserted mid-stream:
  - The next edge clears E and the register file.
  - A W write pending on that edge is discarded.
- `reset` and `E_bubble` both high: reset behaviour.

## Test plan
- Reset with `STACK_INIT`=64'h200 → E_icode=1, E_stat=1000, E_dstE=F. Then `rrmovq %rsp,%rax` → E_valA=0x200.
- `irmovq $5,%rax` flows to W (W_dstE=0, W_valE=5). Next cycle `addq %rax,%rbx` → E_valA=5 with no stall. A later decode also reads 5 from the array.
- Priority: D needs %rdx while e_dstE=2/e_valE=0x11, M_dstM=2/m_valM=0x22, W_dstE=2/W_valE=0x33 → E_valA=0x11. Drop e_dstE to F → 0x22.
- `call` with D_valP=0x40, %rsp=0x200 → E_valA=0x40, E_valB=0x200, E_dstE=4, E_dstM=F.
- `popq %rsp` at W: W_dstE=4/W_valE=0x208 and W_dstM=4/W_valM=0x77 on the same edge → register 4 reads 0x77 afterwards.
- `E_bubble` asserted with `mrmovq` in D → E_icode=1, E_dstM=F. The instruction is re-decoded correctly on the following cycle.
